// File: rtl/ws2812_pkg.sv
// Shared constants and types for the WS2812 APB LED-chain driver.
package ws2812_pkg;

    localparam int OFF_CTRL  = 'h00;
    localparam int OFF_INDEX = 'h04;
    localparam int OFF_DATA  = 'h08;
    localparam int OFF_COUNT = 'h0C;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int STAT_DONE     = 1;
    localparam int STAT_BUSY     = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_LATCH} tx_state_e;
    typedef enum logic [1:0] {BT_IDLE, BT_HIGH, BT_LOW} bit_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Serialises one 24-bit GRB word MSB first with WS2812 high/low timing.
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = 24,
    parameter int T1H_CYC = 48,
    parameter int BIT_CYC = 75
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        load_i,
    input  logic [23:0] word_i,
    output logic        ready_o,
    output logic        led_o
);

    localparam int BW = cnt_w(BIT_CYC);
    localparam logic [BW-1:0] T0_LAST  = BW'(T0H_CYC - 1);
    localparam logic [BW-1:0] T1_LAST  = BW'(T1H_CYC - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYC - 1);

    bit_state_e    state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [23:0]   sh_q, sh_d;
    logic [4:0]    bit_q, bit_d;
    logic          hi_end, bit_end;

    assign hi_end  = cnt_q == (sh_q[23] ? T1_LAST : T0_LAST);
    assign bit_end = cnt_q == BIT_LAST;
    // Ready in the final cycle of the last bit lets the next word start with no gap.
    assign ready_o = (state_q == BT_IDLE) || (state_q == BT_LOW && bit_end && bit_q == 5'd0);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= BT_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            led_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            led_o   <= (state_d == BT_HIGH);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        case (state_q)
            BT_HIGH: begin
                cnt_d = cnt_q + BW'(1);
                if (hi_end) state_d = BT_LOW;
            end
            BT_LOW: begin
                cnt_d = cnt_q + BW'(1);
                if (bit_end) begin
                    if (bit_q != 5'd0) begin
                        sh_d    = {sh_q[22:0], 1'b0};
                        bit_d   = bit_q - 5'd1;
                        cnt_d   = '0;
                        state_d = BT_HIGH;
                    end else begin
                        state_d = BT_IDLE;
                    end
                end
            end
            default: ;
        endcase
        if (load_i && ready_o) begin
            sh_d    = word_i;
            bit_d   = 5'd23;
            cnt_d   = '0;
            state_d = BT_HIGH;
        end
    end

endmodule

// File: rtl/ws2812_apb_driver.sv
// APB-programmed WS2812 strip driver: register file, pixel RAM, frame sequencer and latch.
module ws2812_apb_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS  = 16,
    parameter int ADDR_W    = 6,
    parameter int T0H_CYC   = 24,
    parameter int T1H_CYC   = 48,
    parameter int BIT_CYC   = 75,
    parameter int RESET_CYC = 3000
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    output logic              led_ctl_o,
    input  logic              apb_psel_i,
    input  logic              apb_penable_i,
    input  logic              apb_pwrite_i,
    input  logic [ADDR_W-1:0] apb_paddr_i,
    input  logic [31:0]       apb_pwdata_i,
    output logic [31:0]       apb_prdata_o,
    output logic              apb_pready_o,
    output logic              apb_pslverr_o
);

    localparam int IDX_W = cnt_w(NUM_LEDS);
    localparam int CNT_W = cnt_w(NUM_LEDS + 1);
    localparam int RST_W = cnt_w(RESET_CYC);

    logic [23:0]       ram [NUM_LEDS];
    logic              pready_q;
    logic [IDX_W-1:0]  index_q, pixel_q, pixel_d, pix_nxt;
    logic [CNT_W-1:0]  count_q;
    logic [RST_W-1:0]  lat_q, lat_d;
    logic              done_q, done_set;
    tx_state_e         state_q, state_d;
    logic [ADDR_W-3:0] waddr;
    logic              sel_ctrl, sel_index, sel_data, sel_count;
    logic              fire, wr_ok, err, busy, start_fire;
    logic [31:0]       rdata;
    logic              tx_load, tx_ready;
    logic [23:0]       tx_word;
    logic [1:0]        unused_paddr;

    assign unused_paddr = apb_paddr_i[1:0];
    assign waddr     = apb_paddr_i[ADDR_W-1:2];
    assign sel_ctrl  = waddr == (ADDR_W-2)'(OFF_CTRL / 4);
    assign sel_index = waddr == (ADDR_W-2)'(OFF_INDEX / 4);
    assign sel_data  = waddr == (ADDR_W-2)'(OFF_DATA / 4);
    assign sel_count = waddr == (ADDR_W-2)'(OFF_COUNT / 4);

    // Second access cycle: response is presented and side effects commit here.
    assign fire       = apb_psel_i & apb_penable_i & pready_q;
    assign wr_ok      = fire & apb_pwrite_i & ~err;
    assign busy       = state_q != ST_IDLE;
    assign start_fire = wr_ok & sel_ctrl & apb_pwdata_i[CTRL_START];
    assign pix_nxt    = pixel_q + IDX_W'(1);

    assign apb_pready_o  = pready_q;
    assign apb_pslverr_o = fire & err;
    assign apb_prdata_o  = (fire && !apb_pwrite_i && !err) ? rdata : 32'd0;

    always_comb begin
        rdata = '0;
        err   = 1'b0;
        if (sel_ctrl) begin
            rdata[STAT_DONE] = done_q;
            rdata[STAT_BUSY] = busy;
        end else if (sel_index) begin
            rdata = 32'(index_q);
            err   = apb_pwrite_i && (apb_pwdata_i >= 32'(NUM_LEDS));
        end else if (sel_data) begin
            rdata = {8'h00, ram[index_q]};
            err   = apb_pwrite_i && busy;
        end else if (sel_count) begin
            rdata = 32'(count_q);
            err   = apb_pwrite_i && (busy || apb_pwdata_i > 32'(NUM_LEDS));
        end else begin
            err   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pready_q <= 1'b0;
            index_q  <= '0;
            count_q  <= CNT_W'(NUM_LEDS);
            done_q   <= 1'b0;
        end else begin
            pready_q <= apb_psel_i & apb_penable_i & ~pready_q;
            if (wr_ok && sel_index)
                index_q <= apb_pwdata_i[IDX_W-1:0];
            else if (wr_ok && sel_data)
                index_q <= (index_q == IDX_W'(NUM_LEDS - 1)) ? '0 : index_q + IDX_W'(1);
            if (wr_ok && sel_count)
                count_q <= apb_pwdata_i[CNT_W-1:0];
            if (done_set)
                done_q <= 1'b1;
            else if (wr_ok && sel_ctrl && apb_pwdata_i[CTRL_CLR_DONE])
                done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && sel_data) ram[index_q] <= apb_pwdata_i[23:0];
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            pixel_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            pixel_q <= pixel_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pixel_d  = pixel_q;
        lat_d    = lat_q;
        tx_load  = 1'b0;
        tx_word  = ram[pixel_q];
        done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_fire) begin
                    pixel_d = '0;
                    lat_d   = '0;
                    state_d = (count_q == '0) ? ST_LATCH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_load = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (CNT_W'(pixel_q) + CNT_W'(1) < count_q) begin
                        tx_load = 1'b1;
                        tx_word = ram[pix_nxt];
                        pixel_d = pix_nxt;
                    end else begin
                        lat_d   = '0;
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                lat_d = lat_q + RST_W'(1);
                if (lat_q == RST_W'(RESET_CYC - 1)) begin
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ws2812_bit_tx #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_tx (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .load_i   (tx_load),
        .word_i   (tx_word),
        .ready_o  (tx_ready),
        .led_o    (led_ctl_o)
    );

endmodule

// File: tb/tb_ws2812_apb_driver.sv
// Scoreboard bench: APB responses and LED pulse timing are queued by stimulus, checked by monitors.
module tb_ws2812_apb_driver;

    logic        clk = 1'b0;
    logic        resetn;
    logic        led;
    logic        psel, penable, pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    typedef struct {
        string       nm;
        logic [31:0] rdata;
        logic        err;
    } apb_exp_t;

    typedef struct {
        int hi;
        int lo_before;
        int rise_cyc;
    } pulse_t;

    apb_exp_t    exp_apb[$];
    pulse_t      exp_pulse[$];
    logic [23:0] model_ram [4];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    ws2812_apb_driver #(
        .NUM_LEDS  (4),
        .ADDR_W    (6),
        .T0H_CYC   (2),
        .T1H_CYC   (4),
        .BIT_CYC   (6),
        .RESET_CYC (10)
    ) dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .led_ctl_o     (led),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_pwrite_i  (pwrite),
        .apb_paddr_i   (paddr),
        .apb_pwdata_i  (pwdata),
        .apb_prdata_o  (prdata),
        .apb_pready_o  (pready),
        .apb_pslverr_o (pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apb(input string nm, input bit wr, input logic [5:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
        apb_exp_t e;
        e.nm = nm; e.rdata = exp_rd; e.err = exp_err;
        exp_apb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_until(input int t);
        if (cyc > t) chk("schedule_late", 64'(cyc), 64'(t));
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    // Expected pulses of an nw-word frame (T0H=2, T1H=4, BIT=6).
    task automatic push_frame(input int nw, input int first_rise);
        int prev_hi;
        pulse_t p;
        prev_hi = -1;
        for (int w = 0; w < nw; w++) begin
            for (int b = 23; b >= 0; b--) begin
                p.hi        = model_ram[w][b] ? 4 : 2;
                p.lo_before = (prev_hi < 0) ? -1 : 6 - prev_hi;
                p.rise_cyc  = (prev_hi < 0) ? first_rise : -1;
                exp_pulse.push_back(p);
                prev_hi = p.hi;
            end
        end
    endtask

    // APB monitor: response must appear on the second access cycle.
    int acc = 0;
    always @(negedge clk) begin
        apb_exp_t e;
        if (!resetn) begin
            acc = 0;
        end else if (psel && penable) begin
            acc++;
            if (pready) begin
                if (exp_apb.size() == 0) begin
                    chk("apb_unexpected_response", 64'd1, 64'd0);
                end else begin
                    e = exp_apb.pop_front();
                    chk({e.nm, "_wait"}, 64'(acc), 64'd2);
                    chk({e.nm, "_prdata"}, 64'(prdata), 64'(e.rdata));
                    chk({e.nm, "_pslverr"}, 64'(pslverr), 64'(e.err));
                end
            end else if (acc > 2) begin
                chk("apb_pready_timeout", 64'(acc), 64'd2);
            end
        end else begin
            if (pready) chk("pready_outside_access", 64'(pready), 64'd0);
            acc = 0;
        end
    end

    // LED monitor: measures each high pulse and the low gap before it.
    logic prev_led = 1'b0;
    int   hi_run = 0, lo_run = 0, lo_prev = 0, rise_at = 0;
    always @(negedge clk) begin
        pulse_t p;
        if (!resetn) begin
            prev_led = 1'b0; hi_run = 0; lo_run = 0;
        end else begin
            if (led && !prev_led) begin
                lo_prev = lo_run; rise_at = cyc; hi_run = 1;
            end else if (led) begin
                hi_run++;
            end else if (prev_led) begin
                if (exp_pulse.size() == 0) begin
                    chk("led_unexpected_pulse", 64'd1, 64'd0);
                end else begin
                    p = exp_pulse.pop_front();
                    chk("led_high_width", 64'(hi_run), 64'(p.hi));
                    if (p.lo_before >= 0) chk("led_low_width", 64'(lo_prev), 64'(p.lo_before));
                    if (p.rise_cyc >= 0) chk("led_first_rise", 64'(rise_at), 64'(p.rise_cyc));
                end
                lo_run = 1;
            end else begin
                lo_run++;
            end
            prev_led = led;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int e1, d0, found;
        model_ram[0] = 24'h800001;
        model_ram[1] = 24'h000000;
        model_ram[2] = 24'hFFFFFF;
        model_ram[3] = 24'h0F0F0F;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_led", 64'(led), 64'd0);
        chk("rst_pready", 64'(pready), 64'd0);
        chk("rst_prdata", 64'(prdata), 64'd0);
        chk("rst_pslverr", 64'(pslverr), 64'd0);
        resetn = 1'b1;

        apb("rd_ctrl_rst",  1'b0, 6'h00, 32'd0, 32'h0, 1'b0);
        apb("rd_index_rst", 1'b0, 6'h04, 32'd0, 32'h0, 1'b0);
        apb("rd_count_rst", 1'b0, 6'h0C, 32'd0, 32'h4, 1'b0);

        apb("wr_index0", 1'b1, 6'h04, 32'd0, 32'h0, 1'b0);
        for (int w = 0; w < 4; w++)
            apb("wr_data", 1'b1, 6'h08, {8'h00, model_ram[w]}, 32'h0, 1'b0);
        apb("rd_index_wrap", 1'b0, 6'h04, 32'd0, 32'h0, 1'b0);
        apb("rd_data0",      1'b0, 6'h08, 32'd0, 32'h800001, 1'b0);

        // One-word frame: 24*6 bit cycles then 10 latch cycles.
        apb("wr_count1", 1'b1, 6'h0C, 32'd1, 32'h0, 1'b0);
        apb("start1",    1'b1, 6'h00, 32'd1, 32'h0, 1'b0);
        e1 = cyc + 1;
        push_frame(1, e1);
        wait_until(e1 + 151);
        apb("stat_done1", 1'b0, 6'h00, 32'd0, 32'h2, 1'b0);
        chk("frame1_pulses_left", 64'(exp_pulse.size()), 64'd0);
        apb("clr_done",    1'b1, 6'h00, 32'd2, 32'h0, 1'b0);
        apb("rd_ctrl_clr", 1'b0, 6'h00, 32'd0, 32'h0, 1'b0);

        // Four-word frame with accesses while busy.
        apb("wr_count4", 1'b1, 6'h0C, 32'd4, 32'h0, 1'b0);
        apb("start4",    1'b1, 6'h00, 32'd1, 32'h0, 1'b0);
        e1 = cyc + 1;
        push_frame(4, e1);
        apb("busy_wr_data",  1'b1, 6'h08, 32'h123456, 32'h0, 1'b1);
        apb("busy_wr_count", 1'b1, 6'h0C, 32'd2, 32'h0, 1'b1);
        apb("busy_start",    1'b1, 6'h00, 32'd1, 32'h0, 1'b0);
        apb("busy_rd_ctrl",  1'b0, 6'h00, 32'd0, 32'h4, 1'b0);
        apb("busy_rd_count", 1'b0, 6'h0C, 32'd0, 32'h4, 1'b0);
        apb("busy_rd_data",  1'b0, 6'h08, 32'd0, 32'h800001, 1'b0);
        wait_until(e1 + 582);
        apb("stat_busy_last", 1'b0, 6'h00, 32'd0, 32'h4, 1'b0);
        apb("stat_done4",     1'b0, 6'h00, 32'd0, 32'h2, 1'b0);
        chk("frame4_pulses_left", 64'(exp_pulse.size()), 64'd0);

        // Error and boundary cases.
        apb("rd_bad_off",     1'b0, 6'h10, 32'd0, 32'h0, 1'b1);
        apb("wr_bad_off",     1'b1, 6'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        apb("wr_index_oor",   1'b1, 6'h04, 32'd4, 32'h0, 1'b1);
        apb("rd_index_kept",  1'b0, 6'h04, 32'd0, 32'h0, 1'b0);
        apb("wr_index3",      1'b1, 6'h04, 32'd3, 32'h0, 1'b0);
        apb("rd_data3",       1'b0, 6'h08, 32'd0, 32'h0F0F0F, 1'b0);
        apb("wr_count_oor",   1'b1, 6'h0C, 32'd5, 32'h0, 1'b1);
        apb("rd_count_kept",  1'b0, 6'h0C, 32'd0, 32'h4, 1'b0);
        apb("wr_count0",      1'b1, 6'h0C, 32'd0, 32'h0, 1'b0);
        apb("start0_clr",     1'b1, 6'h00, 32'd3, 32'h0, 1'b0);
        d0 = cyc;
        wait_until(d0 + 6);
        apb("stat_latch0",    1'b0, 6'h00, 32'd0, 32'h4, 1'b0);
        apb("stat_done0",     1'b0, 6'h00, 32'd0, 32'h2, 1'b0);
        // Clear lands on the same edge DONE is set.
        apb("start0b",        1'b1, 6'h00, 32'd1, 32'h0, 1'b0);
        d0 = cyc;
        wait_until(d0 + 6);
        apb("clr_vs_set",     1'b1, 6'h00, 32'd2, 32'h0, 1'b0);
        apb("stat_set_wins",  1'b0, 6'h00, 32'd0, 32'h2, 1'b0);

        // Reset in the middle of a high pulse.
        apb("clr_done2",   1'b1, 6'h00, 32'd2, 32'h0, 1'b0);
        apb("wr_count1b",  1'b1, 6'h0C, 32'd1, 32'h0, 1'b0);
        apb("start_abort", 1'b1, 6'h00, 32'd1, 32'h0, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (led) found = 1;
        end
        chk("led_high_before_reset", 64'(found), 64'd1);
        #2 resetn = 1'b0;
        #1 chk("led_drop_on_reset", 64'(led), 64'd0);
        exp_pulse.delete();
        repeat (2) @(posedge clk); #1;
        resetn = 1'b1;
        apb("rd_ctrl_after_rst",  1'b0, 6'h00, 32'd0, 32'h0, 1'b0);
        apb("rd_count_after_rst", 1'b0, 6'h0C, 32'd0, 32'h4, 1'b0);
        apb("start_after_rst",    1'b1, 6'h00, 32'd1, 32'h0, 1'b0);
        e1 = cyc + 1;
        push_frame(4, e1);
        wait_until(e1 + 590);
        apb("stat_done_after_rst", 1'b0, 6'h00, 32'd0, 32'h2, 1'b0);
        chk("frame_rst_pulses_left", 64'(exp_pulse.size()), 64'd0);

        repeat (5) @(posedge clk); #1;
        chk("apb_responses_left", 64'(exp_apb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_apb_driver.md
Name: ws2812_apb_driver

Overview:
- Parametrised WS2812 LED-chain driver with an APB slave register interface.
- Holds a pixel buffer of NUM_LEDS 24-bit GRB words written by the CPU over APB.
- On a start command, serialises the first LED_COUNT words onto led_ctl_o using WS2812 one-wire timing, then holds the line low for the latch period.
- Sits on the SoC APB bus as a peripheral and drives the external LED strip pin.

Parameters:
- NUM_LEDS, 16: pixel buffer depth; must be at least 1.
- ADDR_W, 6: APB address width.
- T0H_CYC, 24: clock cycles high for a 0 bit.
- T1H_CYC, 48: clock cycles high for a 1 bit.
- BIT_CYC, 75: total clock cycles per bit; must be greater than T1H_CYC, and T1H_CYC greater than T0H_CYC.
- RESET_CYC, 3000: clock cycles of low latch period after the frame.

Ports:
- clk_i  in  1  system clock; the only clock.
- resetn_i  in  1  asynchronous, active-low reset.
- led_ctl_o  out  1  WS2812 data line.
- apb_psel_i  in  1  APB slave select.
- apb_penable_i  in  1  APB enable.
- apb_pwrite_i  in  1  1 = write, 0 = read.
- apb_paddr_i  in  ADDR_W  byte address; bits [1:0] are ignored.
- apb_pwdata_i  in  32  write data.
- apb_prdata_o  out  32  read data.
- apb_pready_o  out  1  transfer complete.
- apb_pslverr_o  out  1  transfer error.

Behaviour:
- Reset (async, resetn_i low):
  - led_ctl_o=0, apb_prdata_o=0, apb_pready_o=0, apb_pslverr_o=0.
  - State IDLE; INDEX=0; LED_COUNT=NUM_LEDS; DONE=0.
  - Pixel RAM is not cleared.
- APB timing:
  - Exactly one wait state. In the first access cycle (psel&penable), pready=0. In the next cycle, pready=1 with prdata and pslverr valid.
  - pready is registered: pready <= psel & penable & ~pready.
  - pready is never high outside an access phase.
  - Register side effects occur once, in the pready=1 cycle.
- Register map:
  - 0x00 CTRL/STAT.
    - Write: bit0 START (self-clearing); bit1 writing 1 clears DONE.
    - Read: bit0=0, bit1 DONE, bit2 BUSY.
  - 0x04 INDEX. R/W, range 0..NUM_LEDS-1. A write of NUM_LEDS or more gives pslverr=1 and INDEX is unchanged.
  - 0x08 DATA.
    - Write: stores pwdata[23:0] at RAM[INDEX], then INDEX increments, wrapping NUM_LEDS-1 -> 0.
    - Read: returns {8'h00, RAM[INDEX]} with no increment.
  - 0x0C LED_COUNT. R/W, range 0..NUM_LEDS. A write greater than NUM_LEDS gives pslverr=1 and the value is ignored.
  - Any other offset: pslverr=1, prdata=0, no effect.
- While BUSY:
  - DATA and LED_COUNT writes give pslverr=1 and are ignored.
  - START is silently ignored (pslverr=0).
  - Reads are always permitted.
- Transmit FSM:
  - IDLE: on START, set BUSY. If LED_COUNT=0 go to LATCH, else go to LOAD with pixel=0.
  - LOAD: fetch RAM[pixel] into a 24-bit shift register; bit=23; go to HIGH.
  - HIGH: led_ctl_o=1 for T1H_CYC cycles if the current bit is 1, else T0H_CYC cycles; then go to LOW.
  - LOW: led_ctl_o=0 until BIT_CYC total cycles have elapsed for the bit. Then:
    - if bits remain, shift and go to HIGH;
    - else if pixel < LED_COUNT-1, pixel++ and go to LOAD;
    - else go to LATCH.
  - LOAD adds no gap: it overlaps the last LOW cycle, so bit periods are exactly BIT_CYC back-to-back.
  - LATCH: led_ctl_o=0 for RESET_CYC cycles; then clear BUSY, set DONE, go to IDLE.
  - Bit order: MSB first, i.e. G7..G0 R7..R0 B7..B0.
  - led_ctl_o is registered.
  - First rising edge on led_ctl_o occurs 1 clock after the START write completes (pready=1 cycle).
- Simultaneous events: a DONE-clear and a set of DONE in the same cycle leaves DONE=1 (set wins).
- Reset mid-frame: led_ctl_o drops to 0 immediately, the FSM returns to IDLE, and the frame is abandoned.

Decomposition:
- Package ws2812_pkg:
  - register offsets (CTRL=0x00, INDEX=0x04, DATA=0x08, COUNT=0x0C);
  - CTRL bit positions;
  - transmit FSM state enum;
  - derived counter widths via $clog2 of BIT_CYC, RESET_CYC and NUM_LEDS+1.
- Sub-module ws2812_bit_tx: takes a 24-bit word with load/ready handshake and generates HIGH/LOW timing and led_ctl_o.
- The top level holds APB decode, pixel RAM, pixel counter and LATCH.

Test Plan:
- Params NUM_LEDS=4, T0H=2, T1H=4, BIT=6, RESET=10. Reset, then read 0x00, 0x04, 0x0C -> 0x0, 0x0, 0x4; led_ctl_o=0; every access shows pready on the 2nd access cycle.
- Write INDEX=0, DATA 0x800001, 0x000000, 0xFFFFFF, 0x0F0F0F; read INDEX -> 0 (wrapped). Set COUNT=1 and START -> first bit high 4 cycles, low 2 cycles; next 22 bits high 2/low 4; last bit high 4; then low 10 cycles; then STAT=0x2.
- COUNT=4 frame -> exactly 96 high pulses, total 96*6+10 cycles from first rise to BUSY=0; pulse widths match the written words.
- While BUSY, write DATA and COUNT -> pslverr=1 and RAM/COUNT unchanged; START -> pslverr=0 and no restart; read 0x00 -> 0x4.
- Access 0x10 -> pslverr=1, prdata=0. Write INDEX=4 -> pslverr=1 and INDEX unchanged. Write COUNT=5 -> pslverr=1. COUNT=0 then START -> led_ctl_o stays 0, DONE set after 10 cycles.
- Assert resetn_i low mid-bit while led_ctl_o=1 -> led_ctl_o=0 the same cycle; after release STAT=0x0 and a new START transmits a normal frame.
